// File: rtl/pc_unit.sv
// pc_unit -- program counter with optional return-address stack (RAS).
//
// Build option: define PC_UNIT_RAS_EN to include the return-address stack.
// Without it, call behaves as jump, ret behaves as a plain increment, and the
// stack status outputs are held at empty / not-full / no-error.
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   clr          asynchronous active-high reset
//   stall        hold out and all stack state this cycle
//   PCSrc        take the conditional branch to branch
//   branch       branch target address
//   jump         unconditional jump to jump_target
//   call         jump to jump_target and push out+INC
//   jump_target  target for jump and call
//   ret          pop the return address into out
//   out          current instruction address (registered)
//   ras_empty    stack holds zero entries
//   ras_full     stack holds RAS_DEPTH entries
//   ras_err      sticky overflow/underflow flag, cleared only by clr
//
// Next-address priority: stall, ret, call, jump, PCSrc, out+INC.

module pc_unit #(
    parameter int             W         = 6,
    parameter int             INC       = 1,
    parameter logic [W-1:0]   RESET_VEC = '0,
    parameter int             RAS_DEPTH = 4
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         stall,
    input  logic         PCSrc,
    input  logic [W-1:0] branch,
    input  logic         jump,
    input  logic         call,
    input  logic [W-1:0] jump_target,
    input  logic         ret,
    output logic [W-1:0] out,
    output logic         ras_empty,
    output logic         ras_full,
    output logic         ras_err
);

    localparam logic [W-1:0] INC_W = W'(INC);

    logic [W-1:0] seq;
    logic [W-1:0] nxt;

    // Sequential address; also the return address pushed by call.
    assign seq = out + INC_W;

`ifdef PC_UNIT_RAS_EN
    localparam int AW = $clog2(RAS_DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  stack [RAS_DEPTH];
    logic [AW-1:0] wp;        // next slot to write; top of stack is wp-1
    logic [AW-1:0] top_idx;
    logic [CW-1:0] count;
    logic [W-1:0]  top;
    logic          do_ret;
    logic          do_push;

    assign top_idx   = wp - AW'(1);
    assign top       = stack[top_idx];
    assign ras_empty = (count == '0);
    assign ras_full  = (count == CW'(RAS_DEPTH));

    // ret wins over call, so a simultaneous call never pushes.
    assign do_ret  = !stall && ret;
    assign do_push = !stall && call && !ret;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            wp      <= '0;
            count   <= '0;
            ras_err <= 1'b0;
        end else if (do_ret) begin
            if (!ras_empty) begin
                wp    <= top_idx;
                count <= count - CW'(1);
            end else begin
                ras_err <= 1'b1;
            end
        end else if (do_push) begin
            // When full, wp already points at the oldest entry, so the
            // write below overwrites it and the count saturates.
            wp <= wp + AW'(1);
            if (ras_full) begin
                ras_err <= 1'b1;
            end else begin
                count <= count + CW'(1);
            end
        end
    end

    // Storage is not reset: entries are unreachable while count is zero.
    always_ff @(posedge clk) begin
        if (do_push) begin
            stack[wp] <= seq;
        end
    end
`else
    assign ras_empty = 1'b1;
    assign ras_full  = 1'b0;
    assign ras_err   = 1'b0;
`endif

    always_comb begin
        nxt = seq;
        if (stall) begin
            nxt = out;
        end else if (ret) begin
`ifdef PC_UNIT_RAS_EN
            nxt = ras_empty ? seq : top;
`else
            nxt = seq;
`endif
        end else if (call || jump) begin
            nxt = jump_target;
        end else if (PCSrc) begin
            nxt = branch;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            out <= RESET_VEC;
        end else begin
            out <= nxt;
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit -- directed self-checking bench for pc_unit (W=6, INC=1,
// RESET_VEC=0, RAS_DEPTH=4). Expected values follow the PC_UNIT_RAS_EN
// setting of the build: with the stack, returns come from the stack;
// without it, call is a jump and ret is a plain increment.

module tb_pc_unit;

`ifdef PC_UNIT_RAS_EN
    localparam bit RAS = 1'b1;
`else
    localparam bit RAS = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       stall = 1'b0;
    logic       PCSrc = 1'b0;
    logic [5:0] branch = '0;
    logic       jump = 1'b0;
    logic       call = 1'b0;
    logic [5:0] jump_target = '0;
    logic       ret = 1'b0;
    logic [5:0] out;
    logic       ras_empty;
    logic       ras_full;
    logic       ras_err;

    int n_cmp = 0;
    int n_bad = 0;

    pc_unit #(
        .W(6),
        .INC(1),
        .RESET_VEC(6'd0),
        .RAS_DEPTH(4)
    ) dut (
        .clk(clk),
        .clr(clr),
        .stall(stall),
        .PCSrc(PCSrc),
        .branch(branch),
        .jump(jump),
        .call(call),
        .jump_target(jump_target),
        .ret(ret),
        .out(out),
        .ras_empty(ras_empty),
        .ras_full(ras_full),
        .ras_err(ras_err)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 ns past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stall = 0; PCSrc = 0; jump = 0; call = 0; ret = 0;
    endtask

    // Asynchronous reset pulse between edges, then release.
    task automatic pulse_clr();
        idle();
        clr = 1;
        #2;
        clr = 0;
    endtask

    task automatic do_jump(input logic [5:0] t);
        idle(); jump = 1; jump_target = t;
        tick();
        idle();
    endtask

    task automatic test_reset();
        logic [5:0] exp_v;
        tick();
        clr = 1;
        #1;
        n_cmp++;
        if (out !== 6'd0 || ras_empty !== 1'b1 || ras_full !== 1'b0 || ras_err !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_async: out=%0d empty=%b full=%b err=%b, required out=0 empty=1 full=0 err=0",
                     out, ras_empty, ras_full, ras_err);
        end
        clr = 0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            exp_v = 6'(i);
            n_cmp++;
            if (out !== exp_v) begin
                n_bad++;
                $display("FAIL reset_count[%0d]: out=%0d required %0d", i, out, exp_v);
            end
        end
        stall = 1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++;
            if (out !== 6'd3) begin
                n_bad++;
                $display("FAIL stall_hold[%0d]: out=%0d required 3", i, out);
            end
        end
        idle();
    endtask

    task automatic test_wrap_branch();
        logic [5:0] exp_seq [3];
        exp_seq[0] = 6'd63; exp_seq[1] = 6'd0; exp_seq[2] = 6'd1;
        do_jump(6'd62);
        n_cmp++;
        if (out !== 6'd62) begin
            n_bad++;
            $display("FAIL jump_62: out=%0d required 62", out);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (out !== exp_seq[i]) begin
                n_bad++;
                $display("FAIL wrap[%0d]: out=%0d required %0d", i, out, exp_seq[i]);
            end
        end
        PCSrc = 1; branch = 6'd20;
        tick();
        idle();
        n_cmp++;
        if (out !== 6'd20) begin
            n_bad++;
            $display("FAIL branch_20: out=%0d required 20", out);
        end
    endtask

    task automatic test_call_ret();
        pulse_clr();
        do_jump(6'd5);
        call = 1; jump_target = 6'd40;
        tick();
        idle();
        n_cmp++;
        if (out !== 6'd40 || ras_empty !== !RAS || ras_full !== 1'b0) begin
            n_bad++;
            $display("FAIL call_40: out=%0d empty=%b full=%b, required out=40 empty=%b full=0",
                     out, ras_empty, ras_full, !RAS);
        end
        ret = 1;
        tick();
        idle();
        n_cmp++;
        if (out !== (RAS ? 6'd6 : 6'd41) || ras_empty !== 1'b1 || ras_err !== 1'b0) begin
            n_bad++;
            $display("FAIL ret_after_call: out=%0d empty=%b err=%b, required out=%0d empty=1 err=0",
                     out, ras_empty, ras_err, RAS ? 6'd6 : 6'd41);
        end
    endtask

    task automatic test_overflow();
        logic [5:0] tgt [5];
        logic [5:0] exp_r [4];
        tgt[0] = 6'd10; tgt[1] = 6'd20; tgt[2] = 6'd30; tgt[3] = 6'd40; tgt[4] = 6'd50;
        if (RAS) begin
            exp_r[0] = 6'd41; exp_r[1] = 6'd31; exp_r[2] = 6'd21; exp_r[3] = 6'd11;
        end else begin
            exp_r[0] = 6'd51; exp_r[1] = 6'd52; exp_r[2] = 6'd53; exp_r[3] = 6'd54;
        end
        pulse_clr();
        do_jump(6'd1);
        for (int i = 0; i < 5; i++) begin
            call = 1; jump_target = tgt[i];
            tick();
            idle();
            n_cmp++;
            if (out !== tgt[i]) begin
                n_bad++;
                $display("FAIL nest_call[%0d]: out=%0d required %0d", i, out, tgt[i]);
            end
            if (i == 3) begin
                n_cmp++;
                if (ras_full !== RAS || ras_err !== 1'b0) begin
                    n_bad++;
                    $display("FAIL fill_4: full=%b err=%b, required full=%b err=0", ras_full, ras_err, RAS);
                end
            end
        end
        n_cmp++;
        if (ras_full !== RAS || ras_err !== RAS) begin
            n_bad++;
            $display("FAIL overflow: full=%b err=%b, required full=%b err=%b", ras_full, ras_err, RAS, RAS);
        end
        for (int i = 0; i < 4; i++) begin
            ret = 1;
            tick();
            idle();
            n_cmp++;
            if (out !== exp_r[i]) begin
                n_bad++;
                $display("FAIL nest_ret[%0d]: out=%0d required %0d", i, out, exp_r[i]);
            end
        end
        n_cmp++;
        if (ras_empty !== 1'b1 || ras_full !== 1'b0 || ras_err !== RAS) begin
            n_bad++;
            $display("FAIL drained: empty=%b full=%b err=%b, required empty=1 full=0 err=%b",
                     ras_empty, ras_full, ras_err, RAS);
        end
    endtask

    task automatic test_underflow_callret();
        pulse_clr();
        do_jump(6'd9);
        ret = 1;
        tick();
        idle();
        n_cmp++;
        if (out !== 6'd10 || ras_err !== RAS || ras_empty !== 1'b1) begin
            n_bad++;
            $display("FAIL underflow: out=%0d err=%b empty=%b, required out=10 err=%b empty=1",
                     out, ras_err, ras_empty, RAS);
        end
        do_jump(6'd32);
        call = 1; jump_target = 6'd50;
        tick();
        // stall must freeze out and the stack even with call and ret pending
        stall = 1; call = 1; ret = 1; jump_target = 6'd7;
        tick();
        n_cmp++;
        if (out !== 6'd50 || ras_empty !== !RAS) begin
            n_bad++;
            $display("FAIL stall_ignores: out=%0d empty=%b, required out=50 empty=%b", out, ras_empty, !RAS);
        end
        stall = 0;
        tick();
        idle();
        n_cmp++;
        if (out !== (RAS ? 6'd33 : 6'd51) || ras_empty !== 1'b1) begin
            n_bad++;
            $display("FAIL call_ret_together: out=%0d empty=%b, required out=%0d empty=1",
                     out, ras_empty, RAS ? 6'd33 : 6'd51);
        end
        n_cmp++;
        if (ras_err !== RAS) begin
            n_bad++;
            $display("FAIL err_sticky: err=%b required %b", ras_err, RAS);
        end
    endtask

    task automatic test_priority();
        pulse_clr();
        jump = 1; PCSrc = 1; jump_target = 6'd12; branch = 6'd20;
        tick();
        idle();
        n_cmp++;
        if (out !== 6'd12) begin
            n_bad++;
            $display("FAIL jump_over_branch: out=%0d required 12", out);
        end
        call = 1; jump = 1; PCSrc = 1; jump_target = 6'd25; branch = 6'd3;
        tick();
        idle();
        n_cmp++;
        if (out !== 6'd25 || ras_empty !== !RAS) begin
            n_bad++;
            $display("FAIL call_with_jump: out=%0d empty=%b, required out=25 empty=%b", out, ras_empty, !RAS);
        end
        ret = 1;
        tick();
        idle();
        n_cmp++;
        if (out !== (RAS ? 6'd13 : 6'd26)) begin
            n_bad++;
            $display("FAIL ret_after_jumpcall: out=%0d required %0d", out, RAS ? 6'd13 : 6'd26);
        end
    endtask

    task automatic test_clr_mid();
        pulse_clr();
        do_jump(6'd3);
        call = 1; jump_target = 6'd10;
        tick();
        call = 1; jump_target = 6'd20;
        tick();
        call = 1; jump_target = 6'd30;
        #3;
        clr = 1;
        #1;
        n_cmp++;
        if (out !== 6'd0 || ras_empty !== 1'b1 || ras_full !== 1'b0 || ras_err !== 1'b0) begin
            n_bad++;
            $display("FAIL clr_mid_call: out=%0d empty=%b full=%b err=%b, required out=0 empty=1 full=0 err=0",
                     out, ras_empty, ras_full, ras_err);
        end
        idle();
        clr = 0;
        tick();
        n_cmp++;
        if (out !== 6'd1) begin
            n_bad++;
            $display("FAIL post_clr_edge: out=%0d required 1", out);
        end
        ret = 1;
        tick();
        idle();
        n_cmp++;
        if (out !== 6'd2 || ras_err !== RAS) begin
            n_bad++;
            $display("FAIL stack_discarded: out=%0d err=%b, required out=2 err=%b", out, ras_err, RAS);
        end
    endtask

    initial begin : watchdog
        #20000;
        $display("FAIL timeout: simulation exceeded 20000 ns");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_wrap_branch();
        test_call_ret();
        test_overflow();
        test_underflow_callret();
        test_priority();
        test_clr_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
